// File: rtl/mem_dma_if.sv
// ---------------------------------------------------------------------------
// mem_dma_if
//
// Memory bus bundle shared by the forth_cpu bus masters and the RAM, port
// and timer responders.
//
// Signals:
//   mem_address  - transaction address (ADDR_BITS wide)
//   mem_nwr      - 1 = read, 0 = write
//   mem_data_out - write data, driven by the master
//   mem_data_in  - read data, driven by the responder
//   mem_valid    - transaction request from the master
//   mem_ready    - registered acknowledge from the responder
//
// Handshake: a transaction completes on the rising clock edge where
// mem_valid=1 and mem_ready=1. The master drops mem_valid on that same edge.
// It holds address, direction and write data constant while mem_valid is
// high. It raises mem_valid again only after it has seen mem_ready low.
// The responder registers mem_ready, so mem_ready never rises in the same
// cycle that mem_valid rises.
//
// Modports:
//   master - bus initiator (this DMA engine or the CPU)
//   slave  - bus responder
// ---------------------------------------------------------------------------
interface mem_dma_if #(
    parameter int ADDR_BITS = 16
);
    logic [ADDR_BITS-1:0] mem_address;
    logic                 mem_nwr;
    logic [15:0]          mem_data_out;
    logic [15:0]          mem_data_in;
    logic                 mem_valid;
    logic                 mem_ready;

    modport master (
        output mem_address,
        output mem_nwr,
        output mem_data_out,
        output mem_valid,
        input  mem_data_in,
        input  mem_ready
    );

    modport slave (
        input  mem_address,
        input  mem_nwr,
        input  mem_data_out,
        input  mem_valid,
        output mem_data_in,
        output mem_ready
    );
endinterface

// File: rtl/mem_dma.sv
// ---------------------------------------------------------------------------
// mem_dma
//
// Copy/fill engine that acts as a second master on the forth_cpu memory
// bus. After a start strobe it moves `count` 16-bit words from src to dst.
// In fill mode it writes fill_value over the destination range instead.
// In copy mode each word is one read transaction followed by one write
// transaction. Top-level arbitration hands the bus to this block while
// busy is high.
//
// Ports:
//   clk         - system clock, all state changes on posedge
//   nreset      - asynchronous active-low reset
//   start       - one-cycle command strobe, ignored while busy
//   fill        - sampled with start: 1 = fill, 0 = copy
//   src, dst    - source / destination start addresses
//   count       - number of words to move
//   fill_value  - word written in fill mode
//   abort       - request an early stop at the next word boundary
//   busy        - high from the accepted start until back in IDLE
//   done        - one-cycle pulse on normal completion
//   error       - sticky timeout flag, cleared by the next accepted start
//   dbg_state_o - current FSM state, for debug and bound checkers
//   bus         - memory bus, master side (see mem_dma_if)
// ---------------------------------------------------------------------------
module mem_dma #(
    parameter int ADDR_BITS    = 16,
    parameter int COUNT_BITS   = 16,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  fill,
    input  logic [ADDR_BITS-1:0]  src,
    input  logic [ADDR_BITS-1:0]  dst,
    input  logic [COUNT_BITS-1:0] count,
    input  logic [15:0]           fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state_o,
    mem_dma_if.master             bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4
    } state_t;

    // The wait counter starts at zero on entry to RD/WR. It gives up when it
    // would reach all-ones, which is 2^TIMEOUT_BITS-1 cycles without ready.
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    src_q, src_d;
    logic [ADDR_BITS-1:0]    dst_q, dst_d;
    logic [COUNT_BITS-1:0]   rem_q, rem_d;
    logic                    fill_q, fill_d;
    logic [15:0]             fval_q, fval_d;
    logic [15:0]             buf_q, buf_d;
    logic                    abort_q, abort_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    valid_q, valid_d;
    logic                    nwr_q, nwr_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    busy_w;

    assign busy_w = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // State register. The bus outputs are registered, so on reset
    // mem_valid drops as soon as nreset falls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            fval_q  <= '0;
            buf_q   <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            nwr_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            fval_q  <= fval_d;
            buf_q   <= buf_d;
            abort_q <= abort_d;
            error_q <= error_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            nwr_q   <= nwr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic. Each transaction is set up
    // on the edge that enters RD/WR. The bus fields are loaded there and
    // then held until ready, which keeps them stable during mem_valid.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        fval_d  = fval_q;
        buf_d   = buf_q;
        // Abort is remembered for the whole run and acted on at WR_GAP exit.
        abort_d = abort_q | (abort & busy_w);
        error_d = error_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        nwr_d   = nwr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    error_d = 1'b0;
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = src;
                        dst_d   = dst;
                        rem_d   = count;
                        fill_d  = fill;
                        fval_d  = fill_value;
                        tmo_d   = '0;
                        valid_d = 1'b1;
                        if (fill) begin
                            state_d = S_WR;
                            nwr_d   = 1'b0;
                            addr_d  = dst;
                            wdata_d = fill_value;
                        end else begin
                            state_d = S_RD;
                            nwr_d   = 1'b1;
                            addr_d  = src;
                        end
                    end
                end
            end

            S_RD: begin
                // Ready is checked before the timeout, so a late ready
                // still completes the read.
                if (bus.mem_ready) begin
                    buf_d   = bus.mem_data_in;
                    valid_d = 1'b0;
                    state_d = S_RD_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RD_GAP: begin
                if (!bus.mem_ready) begin
                    state_d = S_WR;
                    tmo_d   = '0;
                    valid_d = 1'b1;
                    nwr_d   = 1'b0;
                    addr_d  = dst_q;
                    wdata_d = fill_q ? fval_q : buf_q;
                end
            end

            S_WR: begin
                if (bus.mem_ready) begin
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    valid_d = 1'b0;
                    state_d = S_WR_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_WR_GAP: begin
                if (!bus.mem_ready) begin
                    // Completion beats a pending abort on the last word.
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (abort_q || abort) begin
                        state_d = S_IDLE;
                    end else begin
                        tmo_d   = '0;
                        valid_d = 1'b1;
                        if (fill_q) begin
                            state_d = S_WR;
                            nwr_d   = 1'b0;
                            addr_d  = dst_q;
                            wdata_d = fval_q;
                        end else begin
                            state_d = S_RD;
                            nwr_d   = 1'b1;
                            addr_d  = src_q;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy             = busy_w;
    assign done             = done_q;
    assign error            = error_q;
    assign dbg_state_o      = state_q;
    assign bus.mem_valid    = valid_q;
    assign bus.mem_nwr      = nwr_q;
    assign bus.mem_address  = addr_q;
    assign bus.mem_data_out = wdata_q;

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Bus-initiator copy/fill engine for the forth_cpu memory bus. It drives the same mem_valid/mem_ready handshake that the CPU drives toward RAM, port and timer responders.
- Given a start pulse, it moves `count` 16-bit words from a source address to a destination address, or writes a constant to a range. Each word is one read transaction followed by one write transaction.
- It sits beside the CPU as a second bus master; top-level arbitration grants it the bus while busy=1.

Parameters:
- ADDR_BITS, 16, width of mem_address, src and dst.
- COUNT_BITS, 16, width of count and the internal remaining-word counter.
- TIMEOUT_BITS, 8, width of the per-transaction ready timeout counter; timeout fires after 2^TIMEOUT_BITS-1 cycles.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command strobe; honoured only when busy=0.
- fill  input  1  sampled with start: 1 = fill mode, 0 = copy mode.
- src  input  ADDR_BITS  source start address (copy mode).
- dst  input  ADDR_BITS  destination start address.
- count  input  COUNT_BITS  number of words.
- fill_value  input  16  word written in fill mode.
- abort  input  1  request early stop.
- busy  output  1  high from the accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- error  output  1  sticky timeout flag; cleared by the next accepted start.
- mem_address  output  ADDR_BITS  transaction address.
- mem_nwr  output  1  1 = read, 0 = write.
- mem_data_out  output  16  write data.
- mem_data_in  input  16  read data from the responder.
- mem_valid  output  1  transaction request.
- mem_ready  input  1  responder acknowledge; registered by the responder, so it rises at least one cycle after mem_valid.

Behaviour:
- Reset (async, nreset=0):
  - Forces state IDLE and clears busy, done, error, mem_valid.
  - Sets mem_nwr=1, mem_address=0, mem_data_out=0, and clears all internal counters and latches.
  - mem_valid drops immediately, without waiting for clk.
- Handshake:
  - A transaction completes on the posedge where mem_valid=1 and mem_ready=1.
  - On that same edge, mem_valid is registered to 0.
  - Read data is captured from mem_data_in on that edge.
  - mem_address, mem_nwr and mem_data_out stay stable for the whole time mem_valid=1.
  - mem_valid is not reasserted until mem_ready has been sampled 0.
- State IDLE:
  - busy=0.
  - start with count==0: done pulses on the next cycle, no bus activity, error cleared.
  - start with count!=0: latch src, dst, count, fill and fill_value; clear error; set busy=1; go to RD (copy) or WR (fill).
- State RD:
  - mem_valid=1, mem_nwr=1, mem_address=src pointer.
  - On ready: latch the data buffer, then go to RD_GAP.
- State RD_GAP:
  - mem_valid=0.
  - When mem_ready is sampled 0, go to WR.
- State WR:
  - mem_valid=1, mem_nwr=0, mem_address=dst pointer.
  - mem_data_out = buffer (copy) or fill_value (fill).
  - On ready: increment the src and dst pointers (mod 2^ADDR_BITS, wrap 0xFFFF->0x0000), decrement remaining, go to WR_GAP.
- State WR_GAP:
  - mem_valid=0.
  - When mem_ready is sampled 0:
    - remaining==0: go to IDLE and pulse done.
    - pending abort: go to IDLE with no done pulse.
    - otherwise: go to RD (copy) or WR (fill).
- Timeout:
  - The counter is cleared on entry to RD/WR and increments each cycle there without ready.
  - At all-ones: set error=1, drop mem_valid, go to IDLE, no done pulse, busy=0 on the next cycle.
- Abort:
  - Latched whenever busy=1; an in-flight transaction is never cut short.
  - It takes effect only at WR_GAP exit, so a partially copied word is always completed.
  - Abort while IDLE is ignored.
  - A start received while busy=1 is ignored.
- Simultaneous events:
  - abort in the final WR_GAP: done still pulses, because completion takes priority.
  - Timeout and ready on the same edge: ready wins.

Test Plan:
- Copy: src=0x0010, dst=0x0100, count=3; responder asserts ready 1 cycle after valid.
  - Required response: 3 reads at 0x10–0x12, then writes of the same data to 0x100–0x102, strictly alternating read/write.
  - mem_valid is low for ≥1 cycle between transactions.
  - done pulses once; busy falls on the same cycle.
- Fill: dst=0x0040, count=4, fill_value=0xA5A5.
  - Required response: only writes, 0xA5A5 to 0x40–0x43, no read transactions; done pulses once.
- Count 0: start with count=0.
  - Required response: done pulses next cycle, mem_valid stays 0, busy stays 0.
- Timeout: responder never asserts ready.
  - Required response: error=1 after 255 cycles (TIMEOUT_BITS=8), mem_valid=0, busy=0, no done.
  - A following start clears error.
- Abort and wrap:
  - copy dst=0xFFFE, count=4; assert abort during the 2nd read.
    - Required response: exactly 2 writes (0xFFFE and 0xFFFF), then IDLE with no done pulse.
  - Same run without abort.
    - Required response: writes land at 0xFFFE, 0xFFFF, 0x0000 and 0x0001.
- Reset mid-transaction: drop nreset while mem_valid=1 in WR.
  - Required response: mem_valid=0 and busy=0 immediately; error=0 after release.
